// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types for the 2-path polyphase FIR datapath
package fir_pkg;
   localparam int SAMPLE_W = 16;
   localparam int ACC_W    = 32;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [ACC_W-1:0]    acc_t;

   typedef struct packed {
      sample_t even;
      sample_t odd;
   } pair_t;

   typedef enum logic {
      PH_EVEN = 1'b0,
      PH_ODD  = 1'b1
   } phase_e;
endpackage

// File: rtl/fir_sat_round.sv
// rtl/fir_sat_round.sv - combinational round-half-up, arithmetic shift and saturate of one lane
module fir_sat_round #(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 16,
   parameter int SHIFT_AMT = 8
) (
   input  logic signed [IN_W-1:0]  x_i,
   output logic signed [OUT_W-1:0] q_o,
   output logic                    sat_o
);
   localparam int EXT_W = IN_W + 1;
   localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [EXT_W-1:0] x_ext;
   logic signed [EXT_W-1:0] shifted;

   // One guard bit so the rounding bias cannot wrap at the positive limit
   assign x_ext = {x_i[IN_W-1], x_i};

   generate
      if (SHIFT_AMT == 0) begin : g_no_shift
         assign shifted = x_ext;
      end else begin : g_round
         localparam logic signed [EXT_W-1:0] HALF = {{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT_AMT-1);
         logic signed [EXT_W-1:0] biased;
         assign biased  = x_ext + HALF;
         assign shifted = biased >>> SHIFT_AMT;
      end
   endgenerate

   always_comb begin
      q_o   = shifted[OUT_W-1:0];
      sat_o = 1'b0;
      if (shifted > MAX_V) begin
         q_o   = MAX_V[OUT_W-1:0];
         sat_o = 1'b1;
      end else if (shifted < MIN_V) begin
         q_o   = MIN_V[OUT_W-1:0];
         sat_o = 1'b1;
      end
   end
endmodule

// File: rtl/fir_2path_out_serializer.sv
// rtl/fir_2path_out_serializer.sv - quantizes y(2k)/y(2k+1) pairs, buffers them and serializes even-then-odd
// Optional saturation counter enabled by defining FIR_SER_SAT_CNT_EN.
module fir_2path_out_serializer
   import fir_pkg::*;
#(
   parameter int IN_W      = ACC_W,
   parameter int OUT_W     = SAMPLE_W,
   parameter int SHIFT_AMT = 8,
   parameter int DEPTH     = 4
`ifdef FIR_SER_SAT_CNT_EN
   ,
   parameter int CNT_W     = 16
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [IN_W-1:0]      in_even,
   input  logic signed [IN_W-1:0]      in_odd,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [OUT_W-1:0]     out_data,
   output logic                        out_phase,
   output logic [$clog2(DEPTH):0]      level
`ifdef FIR_SER_SAT_CNT_EN
   ,
   output logic [CNT_W-1:0]            sat_count
`endif
);
   localparam int AW = $clog2(DEPTH);

   pair_t          mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    level_q, level_d;
   phase_e         phase_q, phase_d;

   sample_t        q_even, q_odd;
   logic           sat_even, sat_odd;
   pair_t          wr_pair;
   pair_t          head;
   logic           empty, full, push, advance, pop;

   fir_sat_round #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_AMT(SHIFT_AMT)) u_sat_even (
      .x_i   (in_even),
      .q_o   (q_even),
      .sat_o (sat_even)
   );

   fir_sat_round #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_AMT(SHIFT_AMT)) u_sat_odd (
      .x_i   (in_odd),
      .q_o   (q_odd),
      .sat_o (sat_odd)
   );

   assign wr_pair = '{even: q_even, odd: q_odd};
   assign head    = mem_q[rd_ptr_q];

   // Full comes only from the registered level, so a same-cycle pop never frees a slot
   assign empty   = (level_q == '0);
   assign full    = (level_q == (AW+1)'(DEPTH));
   assign push    = in_valid && !full;
   assign advance = !empty && out_ready;
   assign pop     = advance && (phase_q == PH_ODD);

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign out_phase = phase_q;
   assign level     = level_q;
   assign out_data  = empty ? '0 : ((phase_q == PH_ODD) ? head.odd : head.even);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      phase_d  = phase_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         phase_d  = PH_EVEN;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      level_d = level_q + 1'b1;
         else if (!push && pop) level_d = level_q - 1'b1;
         if (advance) phase_d = (phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         phase_q  <= PH_EVEN;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         phase_q  <= phase_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wr_pair;
   end

`ifdef FIR_SER_SAT_CNT_EN
   logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
   logic [CNT_W:0]   sat_sum;

   assign sat_sum = {1'b0, sat_cnt_q} + (CNT_W+1)'({1'b0, sat_even} + {1'b0, sat_odd});

   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (flush)     sat_cnt_d = '0;
      else if (push) sat_cnt_d = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_cnt_q <= '0;
      else     sat_cnt_q <= sat_cnt_d;
   end

   assign sat_count = sat_cnt_q;
`endif
endmodule

// File: tb/tb_fir_2path_out_serializer.sv
// tb/tb_fir_2path_out_serializer.sv - directed self-checking bench for fir_2path_out_serializer
module tb_fir_2path_out_serializer;
   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] in_even;
   logic signed [31:0] in_odd;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_data;
   logic               out_phase;
   logic [2:0]         level;
`ifdef FIR_SER_SAT_CNT_EN
   logic [15:0]        sat_count;
`endif

   int checks = 0;
   int errors = 0;

   fir_2path_out_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_even   (in_even),
      .in_odd    (in_odd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_phase (out_phase),
      .level     (level)
`ifdef FIR_SER_SAT_CNT_EN
      ,
      .sat_count (sat_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pair(input int e, input int o);
      in_valid = 1'b1;
      in_even  = e;
      in_odd   = o;
   endtask

   logic [15:0] exp_q[$];
   int          k;
   int          got;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_even = '0; in_odd = '0; out_ready = 1'b0;
      tick(); tick();
      check("rst_out_valid", {31'b0, out_valid}, 0);
      check("rst_in_ready",  {31'b0, in_ready}, 1);
      check("rst_level",     {29'b0, level}, 0);
      check("rst_out_data",  {16'b0, out_data}, 0);
      rst = 1'b0;
      tick();

      // Rounding: 0x180 -> 2, 0xFFFFFF80 -> 0
      drive_pair(32'h0000_0180, 32'hFFFF_FF80);
      tick();
      in_valid = 1'b0;
      check("rnd_valid", {31'b0, out_valid}, 1);
      check("rnd_even",  {16'b0, out_data}, 32'h0002);
      check("rnd_ph0",   {31'b0, out_phase}, 0);
      check("rnd_level", {29'b0, level}, 1);
      out_ready = 1'b1;
      tick();
      check("rnd_odd",   {16'b0, out_data}, 32'h0000);
      check("rnd_ph1",   {31'b0, out_phase}, 1);
      check("rnd_valid2",{31'b0, out_valid}, 1);
      tick();
      check("rnd_empty", {31'b0, out_valid}, 0);
      check("rnd_lvl0",  {29'b0, level}, 0);
      out_ready = 1'b0;

      // Saturation on both lanes
      drive_pair(32'h7FFF_FFFF, 32'h8000_0000);
      tick();
      in_valid = 1'b0;
      check("sat_pos", {16'b0, out_data}, 32'h7FFF);
`ifdef FIR_SER_SAT_CNT_EN
      check("sat_cnt", {16'b0, sat_count}, 2);
`endif
      out_ready = 1'b1;
      tick();
      check("sat_neg", {16'b0, out_data}, 32'h8000);
      tick();
      check("sat_empty", {31'b0, out_valid}, 0);
      out_ready = 1'b0;

      // Full: four pairs fill the FIFO, the fifth waits for a pop
      for (int i = 0; i < 4; i++) begin
         drive_pair((10 + i) << 8, (20 + i) << 8);
         tick();
      end
      check("full_level", {29'b0, level}, 4);
      check("full_ready", {31'b0, in_ready}, 0);
      drive_pair(99 << 8, 98 << 8);
      tick();
      check("full_hold_level", {29'b0, level}, 4);
      out_ready = 1'b1;
      tick();
      check("full_mid_level", {29'b0, level}, 4);
      check("full_mid_ready", {31'b0, in_ready}, 0);
      tick();
      out_ready = 1'b0;
      check("full_pop_level", {29'b0, level}, 3);
      check("full_pop_ready", {31'b0, in_ready}, 1);
      check("full_head",      {16'b0, out_data}, 11);
      tick();
      in_valid = 1'b0;
      check("full_refill", {29'b0, level}, 4);
      exp_q = {16'd11, 16'd21, 16'd12, 16'd22, 16'd13, 16'd23, 16'd99, 16'd98};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("full_drain", {16'b0, out_data}, {16'b0, exp_q[i]});
         tick();
      end
      check("full_drained", {31'b0, out_valid}, 0);
      out_ready = 1'b0;

      // Ordering under random back-pressure
      exp_q.delete();
      k = 0;
      got = 0;
      for (int cyc = 0; cyc < 2000 && got < 64; cyc++) begin
         in_valid  = (k < 32);
         in_even   = k << 8;
         in_odd    = (k + 100) << 8;
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("ord_spurious", {31'b0, out_valid}, 0);
            end else begin
               check("ord_data",  {16'b0, out_data}, {16'b0, exp_q.pop_front()});
               check("ord_phase", {31'b0, out_phase}, got % 2);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(16'(k));
            exp_q.push_back(16'(k + 100));
            k++;
         end
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("ord_count", got, 64);
      check("ord_level", {29'b0, level}, 0);

      // Flush after the even sample was consumed
      drive_pair(5 << 8, 6 << 8);
      tick();
      drive_pair(7 << 8, 8 << 8);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("fl_pre_phase", {31'b0, out_phase}, 1);
      check("fl_pre_level", {29'b0, level}, 2);
      flush = 1'b1;
      drive_pair(9 << 8, 9 << 8);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_valid", {31'b0, out_valid}, 0);
      check("fl_level", {29'b0, level}, 0);
      check("fl_phase", {31'b0, out_phase}, 0);
`ifdef FIR_SER_SAT_CNT_EN
      check("fl_sat_cnt", {16'b0, sat_count}, 0);
`endif
      drive_pair(1 << 8, 2 << 8);
      tick();
      in_valid = 1'b0;
      check("fl_new_phase", {31'b0, out_phase}, 0);
      check("fl_new_data",  {16'b0, out_data}, 1);

      // Asynchronous reset mid-stream while full
      for (int i = 0; i < 3; i++) begin
         drive_pair(i << 8, i << 8);
         tick();
      end
      in_valid = 1'b0;
      check("ar_pre_ready", {31'b0, in_ready}, 0);
      #2;
      rst = 1'b1;
      #1;
      check("ar_valid", {31'b0, out_valid}, 0);
      check("ar_ready", {31'b0, in_ready}, 1);
      check("ar_level", {29'b0, level}, 0);
      check("ar_data",  {16'b0, out_data}, 0);
      tick();
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
